// File: rtl/store_merge_rmw.sv
// store_merge_rmw: sb/sh/sw to word-wide memory writes, read-modify-write for sub-word stores
module store_merge_rmw #(
  parameter int ADDR_W     = 32,
  parameter int RD_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_we,
  output logic [31:0]       mem_wdata
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WRITE, ERR} state_t;
  localparam int CW = $clog2(RD_TIMEOUT + 1);
  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    lane;
  logic          half;
  logic [15:0]   wd;
  logic          accept, bad, timeout;
  logic [4:0]    sh;
  logic [31:0]   merged;
  assign accept    = req_valid & req_ready;
  assign bad       = (req_size == 2'b11) | (req_size == 2'b01 & req_addr[0]) |
                     (req_size == 2'b10 & |req_addr[1:0]);
  assign timeout   = cnt == CW'(RD_TIMEOUT - 1);
  assign req_ready = state == IDLE;
  assign mem_re    = state == RD_REQ;
  assign mem_we    = state == WRITE;
  assign done      = state == WRITE;
  assign err       = state == ERR;
  assign sh        = {lane, 3'b000};
  assign merged    = half ? (lane[1] ? {wd, mem_rdata[15:0]} : {mem_rdata[31:16], wd})
                          : (mem_rdata & ~(32'hFF << sh)) | ({24'd0, wd[7:0]} << sh);
  // next-state: bad requests detour through ERR so err lands one cycle after accept
  always_comb begin
    nxt = state;
    nxt = state == IDLE    ? (accept ? (bad ? ERR : req_size == 2'b10 ? WRITE : RD_REQ) : IDLE)
        : state == RD_REQ  ? RD_WAIT
        : state == RD_WAIT ? (mem_rvalid ? WRITE : timeout ? ERR : RD_WAIT)
        : IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  // request latch, timeout counter and write-data register (word data on accept, merge on rvalid)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      wd        <= '0;
      lane      <= '0;
      half      <= 1'b0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
        mem_wdata <= req_wdata;
        wd        <= req_wdata[15:0];
        lane      <= req_addr[1:0];
        half      <= req_size[0];
      end
      if (state == RD_WAIT && mem_rvalid) mem_wdata <= merged;
      if (state == RD_REQ) cnt <= '0;
      else if (state == RD_WAIT) cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_store_merge_rmw.sv
// tb_store_merge_rmw: directed store vectors with hand-computed merged words and pulse counts
module tb_store_merge_rmw;
  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, req_ready;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [1:0]  req_size = 0;
  logic        done, err, mem_re, mem_we, mem_rvalid = 0;
  logic [31:0] mem_addr, mem_rdata = 0, mem_wdata;
  int          errors = 0, checks = 0;
  int          nre = 0, nwe = 0, ndone = 0, nerr = 0;
  int          b_re, b_we, b_done, b_err;
  store_merge_rmw #(.ADDR_W(32), .RD_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .done(done), .err(err), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_we(mem_we), .mem_wdata(mem_wdata)
  );
  always #5 clk = ~clk;
  // pulse counters, plus the never-together rules
  always @(posedge clk) begin
    nre   <= nre + int'(mem_re);
    nwe   <= nwe + int'(mem_we);
    ndone <= ndone + int'(done);
    nerr  <= nerr + int'(err);
    if (done && err) $error("FAIL done_err_together");
    if (mem_re && mem_we) $error("FAIL re_we_together");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
    @(negedge clk);
    b_re = nre; b_we = nwe; b_done = ndone; b_err = nerr;
    req_valid = 1; req_addr = a; req_wdata = wd; req_size = sz;
    @(posedge clk);
    #1 req_valid = 0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
  endtask
  task automatic tally(input string tag, input int re, input int we, input int dn, input int er);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(req_ready), 1);
    chk({tag, "_nre"}, nre - b_re, re);
    chk({tag, "_nwe"}, nwe - b_we, we);
    chk({tag, "_ndone"}, ndone - b_done, dn);
    chk({tag, "_nerr"}, nerr - b_err, er);
  endtask
  task automatic rmw(input string tag, input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] sz, input logic [31:0] rd, input int dly,
                     input logic [31:0] exp);
    issue(a, wd, sz);
    chk({tag, "_re"}, 32'(mem_re), 1);
    chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
    repeat (dly) @(negedge clk);
    mem_rvalid = 1; mem_rdata = rd;
    @(negedge clk);
    mem_rvalid = 0; mem_rdata = 32'h5555_5555;
    chk({tag, "_we"}, 32'(mem_we), 1);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_wdata"}, mem_wdata, exp);
    tally(tag, 1, 1, 1, 0);
  endtask
  task automatic bad(input string tag, input logic [31:0] a, input logic [1:0] sz);
    issue(a, 32'h1234_5678, sz);
    chk({tag, "_err"}, 32'(err), 1);
    chk({tag, "_done"}, 32'(done), 0);
    tally(tag, 0, 0, 0, 1);
  endtask
  initial begin
    #2;
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_pulses", {28'd0, done, err, mem_re, mem_we}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    @(negedge clk); rst_n = 1;
    rmw("sb102", 32'h102, 32'h0000_00AB, 2'b00, 32'h1122_3344, 2, 32'h11AB_3344);
    rmw("sh206", 32'h206, 32'h0000_BEEF, 2'b01, 32'hAAAA_BBBB, 1, 32'hBEEF_BBBB);
    rmw("sh204", 32'h204, 32'h0000_BEEF, 2'b01, 32'hAAAA_BBBB, 3, 32'hAAAA_BEEF);
    rmw("sb000", 32'h000, 32'h0000_FF77, 2'b00, 32'hCAFE_BABE, 1, 32'hCAFE_BA77);
    issue(32'h300, 32'hDEAD_BEEF, 2'b10);
    chk("sw_we", 32'(mem_we), 1);
    chk("sw_done", 32'(done), 1);
    chk("sw_re", 32'(mem_re), 0);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("sw_addr", mem_addr, 32'h300);
    tally("sw", 0, 1, 1, 0);
    bad("sh101", 32'h101, 2'b01);
    bad("sw302", 32'h302, 2'b10);
    bad("sz11", 32'h100, 2'b11);
    issue(32'h401, 32'h0000_0099, 2'b00);
    chk("to_re", 32'(mem_re), 1);
    repeat (4) @(negedge clk);
    chk("to_early", 32'(err), 0);
    @(negedge clk);
    chk("to_err", 32'(err), 1);
    chk("to_we", 32'(mem_we), 0);
    tally("to", 1, 0, 0, 1);
    issue(32'h502, 32'h0000_00CC, 2'b00);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("ar_ready", 32'(req_ready), 1);
    chk("ar_pulses", {28'd0, done, err, mem_re, mem_we}, 0);
    chk("ar_addr", mem_addr, 0);
    chk("ar_wdata", mem_wdata, 0);
    mem_rvalid = 1; mem_rdata = 32'h7777_7777;
    @(negedge clk); rst_n = 1;
    @(negedge clk); mem_rvalid = 0;
    repeat (2) @(negedge clk);
    chk("ar_nowrite", nwe - b_we, 0);
    chk("ar_nodone", ndone - b_done, 0);
    rmw("sb003", 32'h003, 32'h0000_005A, 2'b00, 32'h0102_0304, 1, 32'h5A02_0304);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
